instr_fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit CPU. It owns the program counter, issues one read at a time to instruction memory, and holds the fetched word in an IF/ID output register. The 4-bit opcode field of that register drives the control unit's `Opcode` input. It accepts branch redirects from the execute stage and flags or halts on opcodes the control unit does not decode.

---
 rtl/instr_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Fetch stage of the 16-bit CPU: PC, single-outstanding imem reads, IF/ID register.
// Build option IFETCH_ILLEGAL_HALT_EN: stop fetching after an illegal opcode until a redirect.
module instr_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [15:0] ImemRData,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [15:0] Instr,
  output logic [3:0]  Opcode,
  output logic [15:0] InstrPC,
  output logic        IllegalOp,
  output logic        Halted
);

  localparam logic [15:0] LP_STEP = 16'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
`ifdef IFETCH_ILLEGAL_HALT_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_pc;
  logic [15:0] r_req_pc;
  logic        r_drop;
  logic        r_valid;
  logic [15:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_illegal;

  logic        w_issue;
  logic        w_gnt_acc;
  logic        w_load;
  logic        w_consume;
  logic        w_illegal_in;
  logic        w_drop_n;

  function automatic logic f_illegal(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF: f_illegal = 1'b0;
      default:                                             f_illegal = 1'b1;
    endcase
  endfunction

  // STALL reissues in the consume cycle, so a grant can be taken there too.
  assign w_issue      = (r_state == S_FETCH) | ((r_state == S_STALL) & InstrReady);
  assign w_gnt_acc    = w_issue & ImemGnt & ~r_drop;
  assign w_load       = (r_state == S_WAIT) & ImemRValid & ~Redirect;
  assign w_consume    = r_valid & InstrReady;
  assign w_illegal_in = f_illegal(ImemRData[15:12]);

  assign ImemReq    = w_issue & Reset_n;
  assign ImemAddr   = r_pc;
  assign InstrValid = r_valid;
  assign Instr      = r_instr;
  assign Opcode     = r_instr[15:12];
  assign InstrPC    = r_instr_pc;
  assign IllegalOp  = r_illegal;

  // A redirect orphans any read still in flight; its response must be swallowed.
  always_comb begin
    w_drop_n = r_drop & ~ImemRValid;
    if (Redirect) begin
      w_drop_n = w_drop_n | w_gnt_acc | ((r_state == S_WAIT) & ~ImemRValid);
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_FETCH: if (w_gnt_acc) w_state_n = S_WAIT;
      S_WAIT: begin
        if (ImemRValid) begin
`ifdef IFETCH_ILLEGAL_HALT_EN
          w_state_n = w_illegal_in ? S_HALT : S_STALL;
`else
          w_state_n = S_STALL;
`endif
        end
      end
      S_STALL: if (InstrReady) w_state_n = w_gnt_acc ? S_WAIT : S_FETCH;
`ifdef IFETCH_ILLEGAL_HALT_EN
      S_HALT:  w_state_n = S_HALT;
`endif
      default: w_state_n = S_FETCH;
    endcase
    if (Redirect) w_state_n = S_FETCH;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_drop  <= w_drop_n;
      if (Redirect) begin
        r_pc <= RedirectPC;
      end else if (w_gnt_acc) begin
        r_pc <= r_pc + LP_STEP;
      end
      if (w_gnt_acc) r_req_pc <= r_pc;
      if (Redirect) begin
        r_valid   <= 1'b0;
        r_illegal <= 1'b0;
      end else if (w_load) begin
        r_valid    <= 1'b1;
        r_instr    <= ImemRData;
        r_instr_pc <= r_req_pc;
        r_illegal  <= w_illegal_in;
      end else if (w_consume) begin
        r_valid   <= 1'b0;
        r_illegal <= 1'b0;
      end
    end
  end

`ifdef IFETCH_ILLEGAL_HALT_EN
  logic r_halted;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (w_state_n == S_HALT);
    end
  end

  assign Halted = r_halted;
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: imem responder, decode-side scoreboard, directed then random traffic.
module tb_instr_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        ImemReq;
  logic [15:0] ImemAddr;
  logic        ImemGnt = 1'b0;
  logic        ImemRValid = 1'b0;
  logic [15:0] ImemRData = '0;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] Instr;
  logic [3:0]  Opcode;
  logic [15:0] InstrPC;
  logic        IllegalOp;
  logic        Halted;

  always #5 Clock = ~Clock;

  instr_fetch_stage dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRValid (ImemRValid),
    .ImemRData  (ImemRData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instr      (Instr),
    .Opcode     (Opcode),
    .InstrPC    (InstrPC),
    .IllegalOp  (IllegalOp),
    .Halted     (Halted)
  );

  int          n_total = 0;
  int          n_bad = 0;
  int          n_consumed = 0;
  logic [32:0] exp_q[$];     // {illegal, pc, word}
  bit          det_mode = 1'b1;
  int          mem_lat = 0;
  logic        m_pending = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] g_addr = '0;
  int          m_lat = 0;

  task automatic chk(input string tag, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] op;
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0060) return 16'h3000;
    if (a >= 16'h0030 && a <= 16'h003F) return {a[3:0], 12'h5A5};
    case (a[2:0])
      3'd0: op = 4'h0;
      3'd1: op = 4'h1;
      3'd2: op = 4'h2;
      3'd3: op = 4'h9;
      3'd4: op = 4'hA;
      3'd5: op = 4'hB;
      3'd6: op = 4'hC;
      default: op = 4'hD;
    endcase
    return {op, a[11:0]};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return !(op inside {4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF});
  endfunction

  task automatic expect_stream(input logic [15:0] start, input int n);
    logic [15:0] pc;
    logic [15:0] w;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < n; i++) begin
      w = mem_word(pc);
      exp_q.push_back({is_illegal(w[15:12]), pc, w});
      pc = pc + 16'd1;
    end
  endtask

  // Instruction memory: one read at a time, grant then data after m_lat+1 cycles.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      m_pending  = 1'b0;
      ImemGnt    = 1'b0;
      ImemRValid = 1'b0;
      ImemRData  = '0;
    end else begin
      if (ImemRValid) m_pending = 1'b0;
      ImemRValid = 1'b0;
      ImemRData  = '0;
      if (ImemGnt) begin
        m_pending = 1'b1;
        m_addr    = g_addr;
        m_lat     = det_mode ? mem_lat : int'($urandom_range(0, 2));
      end
      ImemGnt = 1'b0;
      if (m_pending) begin
        if (m_lat == 0) begin
          ImemRValid = 1'b1;
          ImemRData  = mem_word(m_addr);
        end else begin
          m_lat--;
        end
      end else if (ImemReq && (det_mode || $urandom_range(0, 2) != 0)) begin
        ImemGnt = 1'b1;
        g_addr  = ImemAddr;
      end
    end
  end

  // Decode-side scoreboard plus hold and qualification checks.
  logic        h_valid = 1'b0;
  logic [15:0] h_instr = '0;
  logic [15:0] h_pc = '0;
  always @(negedge Clock) begin
    logic [32:0] e;
    if (Reset_n) begin
      if (h_valid) begin
        chk("hold_valid", 33'(InstrValid), 33'(1));
        chk("hold_instr", 33'(Instr), 33'(h_instr));
        chk("hold_pc", 33'(InstrPC), 33'(h_pc));
      end
      if (!InstrValid) chk("illegal_qual", 33'(IllegalOp), 33'(0));
      if (InstrValid && InstrReady && !Redirect) begin
        if (exp_q.size() == 0) begin
          chk("q_empty", 33'(InstrPC), 33'h1_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", 33'(InstrPC), 33'(e[31:16]));
          chk("instr", 33'(Instr), 33'(e[15:0]));
          chk("opcode", 33'(Opcode), 33'(e[15:12]));
          chk("illegal", 33'(IllegalOp), 33'(e[32]));
        end
        n_consumed++;
      end
      h_valid = InstrValid && !InstrReady && !Redirect;
      h_instr = Instr;
      h_pc    = InstrPC;
    end else begin
      h_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_grant(input logic [15:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ImemGnt && g_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_wait", 33'(ok), 33'(1));
  endtask

  task automatic wait_consume(input int n);
    int target;
    target = n_consumed + n;
    for (int i = 0; i < 300; i++) begin
      if (n_consumed >= target) break;
      step();
    end
    chk("consume_wait", 33'(n_consumed >= target), 33'(1));
  endtask

  task automatic redirect_to(input logic [15:0] pc, input int n);
    Redirect   = 1'b1;
    RedirectPC = pc;
    expect_stream(pc, n);
    step();
    Redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_redir;
    Reset_n    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    InstrReady = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_req", 33'(ImemReq), 33'(0));
    chk("rst_valid", 33'(InstrValid), 33'(0));
    chk("rst_instr", 33'(Instr), 33'(0));
    chk("rst_opcode", 33'(Opcode), 33'(0));
    chk("rst_pc", 33'(InstrPC), 33'(0));
    chk("rst_illegal", 33'(IllegalOp), 33'(0));
    chk("rst_halted", 33'(Halted), 33'(0));

    // first fetch: grant now, data next cycle, IF/ID valid the cycle after
    step();
    Reset_n = 1'b1;
    expect_stream(16'h0000, 100);
    @(negedge Clock);
    chk("first_req", 33'(ImemReq), 33'(1));
    chk("first_addr", 33'(ImemAddr), 33'(16'h0000));
    repeat (2) @(negedge Clock);
    chk("first_valid", 33'(InstrValid), 33'(1));
    chk("first_opcode", 33'(Opcode), 33'(4'h1));
    chk("first_instr_pc", 33'(InstrPC), 33'(16'h0000));
    chk("first_instr", 33'(Instr), 33'(16'h1234));

    // decode stall for 5 cycles, then combinational reissue
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clock);
      chk("stall_req", 33'(ImemReq), 33'(0));
      chk("stall_instr", 33'(Instr), 33'(16'h1234));
    end
    step();
    InstrReady = 1'b1;
    @(negedge Clock);
    chk("reissue_req", 33'(ImemReq), 33'(1));
    chk("reissue_addr", 33'(ImemAddr), 33'(16'h0001));

    // redirect while the read of addr 5 is still in flight
    wait_grant(16'h0005);
    mem_lat = 2;
    redirect_to(16'h0040, 100);
    mem_lat = 0;
    @(negedge Clock);
    chk("drop_valid", 33'(InstrValid), 33'(0));
    chk("drop_req", 33'(ImemReq), 33'(1));
    chk("drop_addr", 33'(ImemAddr), 33'(16'h0040));

    // redirect in the same cycle as read data
    wait_grant(16'h0043);
    redirect_to(16'h0080, 100);
    @(negedge Clock);
    chk("simul_valid", 33'(InstrValid), 33'(0));
    chk("simul_req", 33'(ImemReq), 33'(1));
    chk("simul_addr", 33'(ImemAddr), 33'(16'h0080));
    step();
    wait_consume(2);

    // PC wrap
    redirect_to(16'hFFFF, 100);
    wait_consume(3);

`ifdef IFETCH_ILLEGAL_HALT_EN
    InstrReady = 1'b0;
    redirect_to(16'h0060, 100);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (InstrValid) break;
    end
    chk("halt_loaded", 33'(InstrValid), 33'(1));
    chk("halt_illegal", 33'(IllegalOp), 33'(1));
    chk("halt_halted", 33'(Halted), 33'(1));
    chk("halt_opcode", 33'(Opcode), 33'(4'h3));
    chk("halt_pc", 33'(InstrPC), 33'(16'h0060));
    step();
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("halt_noreq", 33'(ImemReq), 33'(0));
      chk("halt_stay", 33'(Halted), 33'(1));
    end
    step();
    redirect_to(16'h0010, 100);
    @(negedge Clock);
    chk("unhalt", 33'(Halted), 33'(0));
    step();
    wait_consume(2);
`else
    redirect_to(16'h0030, 100);
    wait_consume(18);
    chk("nohalt_sweep", 33'(Halted), 33'(0));
    redirect_to(16'h0060, 100);
    wait_consume(2);
    chk("nohalt_3000", 33'(Halted), 33'(0));
`endif

    // random traffic: grant delays, latencies, decode backpressure, redirects
    det_mode   = 1'b0;
    prev_redir = 1'b0;
    for (int c = 0; c < 400; c++) begin
      InstrReady = ($urandom_range(0, 3) != 0);
      if (!prev_redir && $urandom_range(0, 11) == 0) begin
        Redirect   = 1'b1;
        RedirectPC = 16'($urandom_range(256, 511));
        expect_stream(RedirectPC, 100);
        prev_redir = 1'b1;
      end else begin
        Redirect   = 1'b0;
        prev_redir = 1'b0;
      end
      step();
    end
    Redirect   = 1'b0;
    InstrReady = 1'b1;
    wait_consume(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
